// File: rtl/argmax_classifier_1x10.sv
// Argmax output stage: captures biased, saturated logits on finish rise,
// scans them one per clock and reports the winning class and its logit.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            global enable; low freezes all state
//   psum, bias    N signed W-bit elements, sampled on the capture cycle
//   finish_in     upstream finish, level-held while psum is valid
//   class_idx     index of the maximum logit (lowest index on ties)
//   max_val       signed value of the maximum logit
//   busy, done    scan in progress / result valid (held until next start)
module argmax_classifier_1x10 #(
   parameter int N  = 10,
   parameter int W  = 16,
   parameter int IW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [N*W-1:0]  psum,
   input  logic            finish_in,
   input  logic [N*W-1:0]  bias,
   output logic [IW-1:0]   class_idx,
   output logic [W-1:0]    max_val,
   output logic            busy,
   output logic            done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [IW-1:0]       LAST    = IW'(N - 1);

   logic [1:0]             state;
   logic                   finish_d;
   logic                   seen_low;
   logic [IW-1:0]          idx;
   logic [IW-1:0]          best_idx;
   logic signed [W-1:0]    run_max;
   logic signed [W-1:0]    logit [N];
   logic signed [W-1:0]    sat   [N];

   logic                   start;
   logic                   take;
   logic signed [W-1:0]    cur;

   for (genvar g = 0; g < N; g++) begin : g_sat
      logic signed [W:0] s;
      assign s = {psum[g*W+W-1], psum[g*W +: W]}
               + {bias[g*W+W-1], bias[g*W +: W]};
      // Overflow when the two top bits of the W+1 sum disagree.
      assign sat[g] = (s[W] != s[W-1]) ? (s[W] ? SAT_MIN : SAT_MAX)
                                       : s[W-1:0];
   end

   // seen_low blocks a start right after reset while finish_in is still
   // high, so only a fresh low-to-high edge can launch a scan.
   assign start = en & finish_in & ~finish_d & seen_low;
   assign cur   = logit[idx];
   assign take  = (idx == '0) || (cur > run_max);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         finish_d  <= 1'b0;
         seen_low  <= 1'b0;
         idx       <= '0;
         best_idx  <= '0;
         run_max   <= '0;
         class_idx <= '0;
         max_val   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < N; i++) logit[i] <= '0;
      end else if (en) begin
         finish_d <= finish_in;
         if (!finish_in) seen_low <= 1'b1;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  for (int i = 0; i < N; i++) logit[i] <= sat[i];
                  idx   <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (take) begin
                  run_max  <= cur;
                  best_idx <= idx;
               end
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  class_idx <= take ? idx : best_idx;
                  max_val   <= take ? cur : run_max;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  idx       <= '0;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_argmax_classifier_1x10.sv
// Testbench for argmax_classifier_1x10: scoreboard of expected winners
// computed from a small integer model, compared when done rises.
module tb_argmax_classifier_1x10;

   localparam int N  = 10;
   localparam int W  = 16;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            finish_in;
   logic [N*W-1:0]  psum;
   logic [N*W-1:0]  bias;
   logic [IW-1:0]   class_idx;
   logic [W-1:0]    max_val;
   logic            busy;
   logic            done;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  val;
   } exp_t;

   exp_t sb[$];
   int   pv[N];
   int   bv[N];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;

   always #5 clk = ~clk;

   argmax_classifier_1x10 #(.N(N), .W(W), .IW(IW)) dut (
      .clk(clk), .rst(rst), .en(en), .psum(psum),
      .finish_in(finish_in), .bias(bias), .class_idx(class_idx),
      .max_val(max_val), .busy(busy), .done(done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_vec;
      for (int i = 0; i < N; i++) begin
         psum[i*W +: W] = W'(pv[i]);
         bias[i*W +: W] = W'(bv[i]);
      end
   endtask

   function automatic exp_t model();
      int   s;
      int   best;
      int   bi;
      exp_t e;
      best = 0;
      bi   = 0;
      for (int i = 0; i < N; i++) begin
         s = pv[i] + bv[i];
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
         if (i == 0 || s > best) begin
            best = s;
            bi   = i;
         end
      end
      e.idx = IW'(bi);
      e.val = W'(best);
      return e;
   endfunction

   task automatic set_basic;
      pv = '{5, -3, 100, 7, 0, 2, 99, -50, 1, 4};
      for (int i = 0; i < N; i++) bv[i] = 0;
   endtask

   // Lowers finish for a cycle, drives vectors, raises finish and
   // records the expected winner. k0 marks the raise point.
   task automatic start_scan(output int k0);
      finish_in = 1'b0;
      tick;
      drive_vec;
      finish_in = 1'b1;
      sb.push_back(model());
      k0 = cyc;
   endtask

   task automatic wait_done(output int dc);
      for (int i = 0; i < 100; i++) begin
         tick;
         if (done === 1'b1) break;
      end
      dc = cyc;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; finish_in = 1'b0;
      psum = '0; bias = '0;
      repeat (3) tick;
      total_cnt++;
      if (class_idx !== '0) $display("FAIL rst_idx got %0d exp 0", class_idx);
      else pass_cnt++;
      total_cnt++;
      if (max_val !== '0) $display("FAIL rst_val got %0d exp 0", max_val);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy);
      else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done);
      else pass_cnt++;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_basic;
      int   k0;
      exp_t e;
      set_basic;
      start_scan(k0);
      for (int t = 1; t <= 11; t++) begin
         tick;
         total_cnt++;
         if (t <= 10) begin
            if (busy !== 1'b1 || done !== 1'b0)
               $display("FAIL basic_busy t=%0d got busy=%b done=%b exp 1/0",
                        t, busy, done);
            else pass_cnt++;
         end else begin
            if (busy !== 1'b0 || done !== 1'b1)
               $display("FAIL basic_done t=%0d got busy=%b done=%b exp 0/1",
                        t, busy, done);
            else pass_cnt++;
         end
         if (t == 5) begin
            total_cnt++;
            if (class_idx !== '0 || max_val !== '0)
               $display("FAIL basic_hold got %0d/%0d exp 0/0",
                        class_idx, $signed(max_val));
            else pass_cnt++;
         end
      end
      e = sb.pop_front();
      total_cnt++;
      if (class_idx !== e.idx)
         $display("FAIL basic_idx got %0d exp %0d", class_idx, e.idx);
      else pass_cnt++;
      total_cnt++;
      if (max_val !== e.val)
         $display("FAIL basic_val got %0d exp %0d",
                  $signed(max_val), $signed(e.val));
      else pass_cnt++;
   endtask

   task automatic test_tie_neg;
      int   k0;
      int   dc;
      exp_t e;
      for (int i = 0; i < N; i++) begin pv[i] = -20; bv[i] = 0; end
      pv[3] = -1;
      pv[8] = -1;
      start_scan(k0);
      repeat (3) tick;
      // Retrigger mid-scan and change psum: both must be ignored.
      finish_in = 1'b0;
      tick;
      finish_in = 1'b1;
      for (int i = 0; i < N; i++) pv[i] = 1000;
      drive_vec;
      tick;
      total_cnt++;
      if (class_idx !== 4'd2 || $signed(max_val) !== 16'sd100 || done !== 1'b0)
         $display("FAIL tie_hold got %0d/%0d done=%b exp 2/100 done=0",
                  class_idx, $signed(max_val), done);
      else pass_cnt++;
      wait_done(dc);
      total_cnt++;
      if (dc - k0 != 11)
         $display("FAIL tie_latency got %0d exp 11", dc - k0);
      else pass_cnt++;
      e = sb.pop_front();
      total_cnt++;
      if (class_idx !== e.idx || max_val !== e.val)
         $display("FAIL tie_result got %0d/%0d exp %0d/%0d", class_idx,
                  $signed(max_val), e.idx, $signed(e.val));
      else pass_cnt++;
   endtask

   task automatic test_bias_sat;
      int   k0;
      int   dc;
      exp_t e;
      for (int i = 0; i < N; i++) begin pv[i] = i * 3; bv[i] = 0; end
      pv[4] = 32760;  bv[4] = 100;
      pv[0] = -32760; bv[0] = -100;
      start_scan(k0);
      wait_done(dc);
      e = sb.pop_front();
      total_cnt++;
      if (dc - k0 != 11 || class_idx !== e.idx || max_val !== e.val)
         $display("FAIL sat_pos got %0d/%0d lat %0d exp %0d/%0d lat 11",
                  class_idx, $signed(max_val), dc - k0, e.idx, $signed(e.val));
      else pass_cnt++;
      for (int i = 0; i < N; i++) begin pv[i] = -32760; bv[i] = -100; end
      start_scan(k0);
      wait_done(dc);
      e = sb.pop_front();
      total_cnt++;
      if (class_idx !== e.idx || max_val !== e.val)
         $display("FAIL sat_neg got %0d/%0d exp %0d/%0d", class_idx,
                  $signed(max_val), e.idx, $signed(e.val));
      else pass_cnt++;
   endtask

   task automatic test_level_finish;
      int   k0;
      int   dc;
      int   rises;
      logic prev;
      exp_t e;
      set_basic;
      start_scan(k0);
      rises = 0;
      prev  = done;
      for (int t = 0; t < 40; t++) begin
         tick;
         if (done === 1'b1 && prev === 1'b0) rises++;
         prev = done;
      end
      total_cnt++;
      if (rises != 1) $display("FAIL level_rises got %0d exp 1", rises);
      else pass_cnt++;
      e = sb.pop_front();
      total_cnt++;
      if (class_idx !== e.idx || max_val !== e.val)
         $display("FAIL level_result got %0d/%0d exp %0d/%0d", class_idx,
                  $signed(max_val), e.idx, $signed(e.val));
      else pass_cnt++;
      finish_in = 1'b0;
      tick;
      pv[9] = 500;
      drive_vec;
      finish_in = 1'b1;
      sb.push_back(model());
      k0 = cyc;
      tick;
      total_cnt++;
      if (done !== 1'b0 || class_idx !== 4'd2 || $signed(max_val) !== 16'sd100)
         $display("FAIL restart_hold got done=%b %0d/%0d exp done=0 2/100",
                  done, class_idx, $signed(max_val));
      else pass_cnt++;
      wait_done(dc);
      e = sb.pop_front();
      total_cnt++;
      if (dc - k0 != 11 || class_idx !== e.idx || max_val !== e.val)
         $display("FAIL restart_result got %0d/%0d lat %0d exp %0d/%0d lat 11",
                  class_idx, $signed(max_val), dc - k0, e.idx, $signed(e.val));
      else pass_cnt++;
   endtask

   task automatic test_stall;
      int   k0;
      int   dc;
      exp_t e;
      set_basic;
      start_scan(k0);
      repeat (6) tick;
      en = 1'b0;
      repeat (5) tick;
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL stall_frozen got busy=%b done=%b exp 1/0", busy, done);
      else pass_cnt++;
      en = 1'b1;
      wait_done(dc);
      total_cnt++;
      if (dc - k0 != 16)
         $display("FAIL stall_latency got %0d exp 16", dc - k0);
      else pass_cnt++;
      e = sb.pop_front();
      total_cnt++;
      if (class_idx !== e.idx || max_val !== e.val)
         $display("FAIL stall_result got %0d/%0d exp %0d/%0d", class_idx,
                  $signed(max_val), e.idx, $signed(e.val));
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int   k0;
      int   dc;
      logic active;
      exp_t e;
      for (int i = 0; i < N; i++) begin pv[i] = -i; bv[i] = 0; end
      pv[6] = 77;
      start_scan(k0);
      repeat (7) tick;
      rst = 1'b1;
      tick;
      sb.delete();
      total_cnt++;
      if (class_idx !== '0 || max_val !== '0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL midrst_out got %0d/%0d busy=%b done=%b exp all 0",
                  class_idx, max_val, busy, done);
      else pass_cnt++;
      rst    = 1'b0;
      active = 1'b0;
      repeat (15) begin
         tick;
         if (busy !== 1'b0 || done !== 1'b0) active = 1'b1;
      end
      total_cnt++;
      if (active !== 1'b0)
         $display("FAIL midrst_nostart got activity=%b exp 0", active);
      else pass_cnt++;
      start_scan(k0);
      wait_done(dc);
      e = sb.pop_front();
      total_cnt++;
      if (dc - k0 != 11 || class_idx !== e.idx || max_val !== e.val)
         $display("FAIL midrst_rescan got %0d/%0d lat %0d exp %0d/%0d lat 11",
                  class_idx, $signed(max_val), dc - k0, e.idx, $signed(e.val));
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_tie_neg;
      test_bias_sat;
      test_level_finish;
      test_stall;
      test_reset_mid;
      total_cnt++;
      if (sb.size() != 0)
         $display("FAIL scoreboard_left got %0d exp 0", sb.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/argmax_classifier_1x10.md
Name: argmax_classifier_1x10

Overview:
- Output stage directly downstream of the 1x64 by 64x10 matrix-vector PE array.
- Captures the 10-element signed psum vector when the upstream finish rises, adds a per-class bias with saturation, and scans the logits sequentially, one per clock.
- Reports the winning class index, its logit value and a level-held done flag.
- Its results feed the network's classification result register.

Parameters:
- N, 10, number of classes (elements in psum).
- W, 16, bit width of each signed psum, bias and logit element.
- IW, 4, width of the class index; must satisfy 2^IW >= N.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low, all state is frozen.
- psum  input  N*W  upstream result vector. Element i is psum[i*W +: W], signed.
- finish_in  input  1  upstream finish; level-held high while psum is valid.
- bias  input  N*W  per-class signed bias. Element i is bias[i*W +: W]. Static during a scan.
- class_idx  output  IW  index of the maximum logit.
- max_val  output  W  signed value of the maximum logit.
- busy  output  1  high while capture or scan is in progress.
- done  output  1  high once a result is valid; held until the next start or reset.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: class_idx=0, max_val=0, busy=0, done=0, state=IDLE, finish_d=0, scan index=0, running max=0, logit registers=0.
- Reset mid-scan aborts immediately. No result is produced, and the next start requires a fresh finish_in rising edge.
- en=0 freezes the FSM, counters, finish_d and outputs. Edges of finish_in during en=0 are not seen until en returns high.
- Start condition: start = en & finish_in & ~finish_d, where finish_d is finish_in registered whenever en=1.
- FSM states:
  - IDLE: on start, go to SCAN.
  - SCAN: runs for N cycles, then goes to DONE.
  - DONE: holds outputs; on start, goes to SCAN.
- Capture, on the start cycle:
  - logit[i] = sat_W(psum[i] + bias[i]), computed in W+1 bits.
  - Saturation clamps to +2^(W-1)-1 or -2^(W-1).
  - In the same cycle: idx=0, busy=1, done=0.
- Scan, one element per clock:
  - At idx=0, running max is loaded with logit[0] and best index with 0.
  - For idx>0, update only if logit[idx] > running max (signed, strict). Ties therefore keep the lowest index.
  - idx increments by 1 each cycle.
- Completion:
  - On the cycle that processes idx=N-1, class_idx and max_val take the final values.
  - In that same cycle: done=1, busy=0, state goes to DONE.
- Latency: if start is sampled at posedge k, done is high after posedge k+N (k+10 for defaults). No en-low cycles are counted.
- class_idx and max_val change only at completion. They hold their previous result during a scan.
- A start during SCAN is ignored. The captured logits are unaffected by later psum changes.
- A start in DONE restarts: done drops in the capture cycle, and the old class_idx/max_val hold until the new completion.
- finish_in held high continuously produces exactly one scan. It must go low, then high, to restart.
- psum and bias are sampled only in the capture cycle.

Test Plan:
- Basic argmax: psum elements = {5,-3,100,7,0,2,99,-50,1,4}, bias=0, finish_in rises at cycle k -> done=1 after posedge k+10, class_idx=2, max_val=100, busy high exactly for posedges k..k+9.
- Tie and negatives: all elements -20 except elements 3 and 8 = -1, bias=0 -> class_idx=3, max_val=-1 (signed compare, lowest index wins).
- Bias and saturation:
  - psum[4]=32760, bias[4]=100 -> logit 32767 (clamped); all others small -> class_idx=4, max_val=32767.
  - psum[0]=-32760, bias[0]=-100 -> logit[0] = -32768.
- Level-held finish and restart:
  - Hold finish_in high for 40 cycles -> exactly one done rising.
  - Drop finish_in low, change psum so element 9 = 500, raise finish_in -> done drops, and after 10 cycles class_idx=9, max_val=500. The old result holds in between.
- Enable stall: deassert en for 5 cycles mid-scan after idx=4 -> done is delayed by exactly 5 cycles and the result is unchanged versus the no-stall run.
- Reset mid-scan: assert rst at scan idx=6 -> next cycle all outputs 0, state IDLE. With finish_in still high after rst drops, no scan starts until finish_in toggles low then high.
